bcd_scan_display: RTL and testbench
===================================

BCD_SCAN_DISPLAY -- requirements
Module: bcd_scan_display

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 100000, clock cycles each digit stays selected; legal range 2..2^24.
REQ-003 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port value, input, 4*NUM_DIGITS, one nibble per digit; digit 0 = bits [3:0] (least significant).
REQ-006 Port dp_in, input, NUM_DIGITS, decimal point request per digit, 1 = lit.
REQ-007 Port load, input, 1, one-cycle strobe capturing value and dp_in into shadow registers.
REQ-008 Port hex_en, input, 1, 1 = codes 10..15 shown as A,b,C,d,E,F; 0 = shown as dash.
REQ-009 Port blank_lz, input, 1, 1 = leading-zero suppression enabled.
REQ-010 Port en, input, 1, 0 = all anodes off; scanning continues.
REQ-011 Port seg, output, 7, segment drive, order gfedcba (bit 6 = g), active-low.
REQ-012 Port dp, output, 1, decimal point drive, active-low.
REQ-013 Port an, output, NUM_DIGITS, digit anode select, one-hot active-low.

Function
REQ-014 Shadow registers (value, dp) SHALL update only on the clock edge where load=1; the display SHALL never show a mix of old and new values within one digit slot.
REQ-015 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; tick = prescaler at REFRESH_DIV-1.
REQ-016 Digit index idx SHALL advance by 1 on each tick and wrap from NUM_DIGITS-1 to 0; NUM_DIGITS=1 holds idx at 0.
REQ-017 seg, dp, an SHALL be registered, computed from idx, shadow and live hex_en/blank_lz/en of the previous cycle (1-cycle latency).
REQ-018 an SHALL drive bit idx low and all others high when en=1; all bits high when en=0.
REQ-019 Decode 0..9 SHALL be: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
REQ-020 Decode 10..15 with hex_en=1 SHALL be: 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
REQ-021 Decode 10..15 with hex_en=0 SHALL be dash 0111111.
REQ-022 With blank_lz=1, digit i>0 SHALL be blanked (seg=1111111) when its nibble and every higher nibble equal 0; digit 0 is never blanked.
REQ-023 Blanked digits SHALL still drive dp per shadow dp bit.
REQ-024 dp SHALL be the inverse of the shadow dp bit for the selected digit.
REQ-025 load coinciding with a tick SHALL capture new data, and the new digit's slot SHALL show the new data.
REQ-026 Changes on en, hex_en, blank_lz SHALL take effect on the output one cycle later, without resetting prescaler or idx.

Reset
REQ-027 On rst=1 at a clock edge: prescaler=0, idx=0, shadow value=0, shadow dp=0, seg=1111111, dp=1, an=all ones.
REQ-028 rst SHALL override load, en and tick in the same cycle.
REQ-029 Reset mid-scan SHALL restart at digit 0 with a full REFRESH_DIV slot.

Verification (NUM_DIGITS=4, REFRESH_DIV=4)
REQ-030 Reset, then load value=16'h1234, en=1, hex_en=0, blank_lz=0 -> an cycles 1110,1101,1011,0111 every 4 cycles; seg 0011001(4), 0110000(3), 0100100(2), 1111001(1).
REQ-031 load value=16'h00A7 with hex_en=0, then hex_en=1 -> digit 1 seg 0111111, then 0001000 one cycle after the hex_en change.
REQ-032 load value=16'h0050, blank_lz=1, dp_in=4'b1000 -> digits 3,2 seg=1111111 with digit 3 dp=0; digit 1 = 0010010; digit 0 = 1000000.
REQ-033 load 16'h0000 with blank_lz=1 -> digits 1..3 blank, digit 0 shows 1000000.
REQ-034 load 16'h9999, then at the tick edge load 16'h8888 -> the next slot shows 0000000, never 0010000.
REQ-035 Assert rst during digit 2 slot -> next cycle an=1111, seg=1111111, dp=1; after release digit 0 is selected for exactly 4 cycles.

Source files
------------

// File: rtl/bcd_scan_display.sv
// Multiplexed 7-segment BCD/hex scanner with shadowed data, leading-zero blanking,
// and registered outputs that lag the digit index by one cycle.
module bcd_scan_display #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 100000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   input  logic                    hex_en,
   input  logic                    blank_lz,
   input  logic                    en,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an
);

   localparam int               PRE_W    = 24;
   localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [6:0]       SEG_OFF  = 7'b1111111;
   localparam logic [6:0]       SEG_DASH = 7'b0111111;

   logic [PRE_W-1:0]        presc;
   logic                    tick;
   logic [IDX_W-1:0]        idx;
   logic [4*NUM_DIGITS-1:0] shadow_val;
   logic [NUM_DIGITS-1:0]   shadow_dp;
   logic [3:0]              nib [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   zero_from;
   logic [3:0]              cur_nib;
   logic                    blank;
   logic [6:0]              seg_nxt;
   logic                    dp_nxt;
   logic [NUM_DIGITS-1:0]   an_nxt;

   // Segment order gfedcba, active-low.
   function automatic logic [6:0] decode(input logic [3:0] code, input logic hex);
      case (code)
         4'd0:    decode = 7'b1000000;
         4'd1:    decode = 7'b1111001;
         4'd2:    decode = 7'b0100100;
         4'd3:    decode = 7'b0110000;
         4'd4:    decode = 7'b0011001;
         4'd5:    decode = 7'b0010010;
         4'd6:    decode = 7'b0000010;
         4'd7:    decode = 7'b1111000;
         4'd8:    decode = 7'b0000000;
         4'd9:    decode = 7'b0010000;
         4'd10:   decode = hex ? 7'b0001000 : SEG_DASH;
         4'd11:   decode = hex ? 7'b0000011 : SEG_DASH;
         4'd12:   decode = hex ? 7'b1000110 : SEG_DASH;
         4'd13:   decode = hex ? 7'b0100001 : SEG_DASH;
         4'd14:   decode = hex ? 7'b0000110 : SEG_DASH;
         default: decode = hex ? 7'b0001110 : SEG_DASH;
      endcase
   endfunction

   assign tick = (presc == PRE_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         presc <= '0;
         idx   <= '0;
      end else begin
         presc <= tick ? '0 : presc + PRE_W'(1);
         if (tick)
            idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end
   end

   // Shadow is the only source of displayed data, so a digit never mixes old and new.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_val <= '0;
         shadow_dp  <= '0;
      end else if (load) begin
         shadow_val <= value;
         shadow_dp  <= dp_in;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_DIGITS; i++)
         nib[i] = shadow_val[4*i +: 4];
   end

   // zero_from[i] = nibble i and every higher nibble are zero.
   always_comb begin
      zero_from = '0;
      zero_from[NUM_DIGITS-1] = (nib[NUM_DIGITS-1] == 4'd0);
      for (int i = NUM_DIGITS - 2; i >= 0; i--)
         zero_from[i] = zero_from[i+1] & (nib[i] == 4'd0);
   end

   always_comb begin
      cur_nib = nib[idx];
      blank   = blank_lz && (idx != '0) && zero_from[idx];
      seg_nxt = blank ? SEG_OFF : decode(cur_nib, hex_en);
      dp_nxt  = ~shadow_dp[idx];
      an_nxt  = '1;
      if (en)
         an_nxt[idx] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seg <= SEG_OFF;
         dp  <= 1'b1;
         an  <= '1;
      end else begin
         seg <= seg_nxt;
         dp  <= dp_nxt;
         an  <= an_nxt;
      end
   end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Bench for bcd_scan_display: per-cycle comparison against a slot-arithmetic model,
// directed literal checks on the scan/decode/blank/reset scenarios, then random traffic.
module tb_bcd_scan_display;

   localparam int N = 4;
   localparam int R = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [15:0]   value;
   logic [3:0]    dp_in;
   logic          load, hex_en, blank_lz, en;
   logic [6:0]    seg;
   logic          dp;
   logic [3:0]    an;

   int n_chk  = 0;
   int n_fail = 0;

   bcd_scan_display #(.NUM_DIGITS(N), .REFRESH_DIV(R)) dut (
      .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
      .hex_en(hex_en), .blank_lz(blank_lz), .en(en),
      .seg(seg), .dp(dp), .an(an)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: k counts clean edges since reset; the digit feeding an output is (k/R)%N.
   logic [6:0] dec_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
   int          k;
   int          md;
   logic [3:0]  mnib;
   logic [15:0] m_val;
   logic [3:0]  m_dp;
   logic [6:0]  e_seg;
   logic        e_dp;
   logic [3:0]  e_an;
   bit          model_valid = 0;

   always @(posedge clk) begin
      if (rst) begin
         k = 0; m_val = '0; m_dp = '0;
         e_seg = 7'b1111111; e_dp = 1'b1; e_an = 4'b1111;
         model_valid = 1;
      end else if (model_valid) begin
         md   = (k / R) % N;
         mnib = 4'(m_val >> (4*md));
         if (blank_lz && md > 0 && (m_val >> (4*md)) == 16'd0)
            e_seg = 7'b1111111;
         else if (mnib >= 4'd10 && !hex_en)
            e_seg = 7'b0111111;
         else
            e_seg = dec_tab[mnib];
         e_dp = ~m_dp[md];
         e_an = en ? ~(4'b0001 << md) : 4'b1111;
         if (load) begin
            m_val = value;
            m_dp  = dp_in;
         end
         k++;
      end
   end

   always @(negedge clk) begin
      if (model_valid) begin
         chk("model_seg", {25'd0, seg}, {25'd0, e_seg});
         chk("model_dp",  {31'd0, dp},  {31'd0, e_dp});
         chk("model_an",  {28'd0, an},  {28'd0, e_an});
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset;
      rst = 1'b1; load = 1'b0;
      step(1);
      rst = 1'b0;
   endtask

   task automatic lit(input string name, input logic [6:0] s, input logic d, input logic [3:0] a);
      chk({name, "_seg"}, {25'd0, seg}, {25'd0, s});
      chk({name, "_dp"},  {31'd0, dp},  {31'd0, d});
      chk({name, "_an"},  {28'd0, an},  {28'd0, a});
   endtask

   initial begin
      rst = 1'b1; value = '0; dp_in = '0; load = 1'b0;
      hex_en = 1'b0; blank_lz = 1'b0; en = 1'b1;
      step(1);
      lit("reset", 7'b1111111, 1'b1, 4'b1111);

      // Basic scan of 1234
      do_reset;
      value = 16'h1234; load = 1'b1;
      step(1); load = 1'b0;
      lit("scan_e1", 7'b1000000, 1'b1, 4'b1110);
      step(1); lit("scan_d0", 7'b0011001, 1'b1, 4'b1110);
      step(3); lit("scan_d1", 7'b0110000, 1'b1, 4'b1101);
      step(4); lit("scan_d2", 7'b0100100, 1'b1, 4'b1011);
      step(4); lit("scan_d3", 7'b1111001, 1'b1, 4'b0111);

      // Dash then hex A on digit 1
      do_reset;
      value = 16'h00A7; load = 1'b1;
      step(1); load = 1'b0;
      step(4); lit("dash_d1", 7'b0111111, 1'b1, 4'b1101);
      hex_en = 1'b1;
      step(1); lit("hex_d1", 7'b0001000, 1'b1, 4'b1101);
      hex_en = 1'b0;

      // Leading-zero blanking with dp on a blanked digit
      do_reset;
      value = 16'h0050; dp_in = 4'b1000; blank_lz = 1'b1; load = 1'b1;
      step(1); load = 1'b0;
      step(1); lit("lz_d0", 7'b1000000, 1'b1, 4'b1110);
      step(3); lit("lz_d1", 7'b0010010, 1'b1, 4'b1101);
      step(4); lit("lz_d2", 7'b1111111, 1'b1, 4'b1011);
      step(4); lit("lz_d3", 7'b1111111, 1'b0, 4'b0111);

      // All-zero value: only digit 0 lit
      do_reset;
      value = 16'h0000; dp_in = 4'b0000; load = 1'b1;
      step(1); load = 1'b0;
      step(1); lit("z_d0", 7'b1000000, 1'b1, 4'b1110);
      step(3); lit("z_d1", 7'b1111111, 1'b1, 4'b1101);
      step(4); lit("z_d2", 7'b1111111, 1'b1, 4'b1011);
      step(4); lit("z_d3", 7'b1111111, 1'b1, 4'b0111);
      blank_lz = 1'b0;

      // Load on the tick edge
      do_reset;
      value = 16'h9999; load = 1'b1;
      step(1); load = 1'b0;
      step(2);
      value = 16'h8888; load = 1'b1;
      step(1); load = 1'b0;
      lit("tick_old", 7'b0010000, 1'b1, 4'b1110);
      for (int i = 0; i < 4; i++) begin
         step(1); lit("tick_new", 7'b0000000, 1'b1, 4'b1101);
      end

      // Reset during digit 2 slot
      do_reset;
      value = 16'h1234; load = 1'b1;
      step(1); load = 1'b0;
      step(9);
      lit("pre_rst_d2", 7'b0100100, 1'b1, 4'b1011);
      rst = 1'b1;
      step(1); rst = 1'b0;
      lit("mid_rst", 7'b1111111, 1'b1, 4'b1111);
      for (int i = 0; i < 4; i++) begin
         step(1); lit("rst_slot0", 7'b1000000, 1'b1, 4'b1110);
      end
      step(1); lit("rst_slot1", 7'b1000000, 1'b1, 4'b1101);

      // Random traffic against the model
      do_reset;
      for (int c = 0; c < 3000; c++) begin
         rst  = ($urandom_range(0, 299) == 0);
         load = ($urandom_range(0, 7) == 0);
         for (int j = 0; j < 4; j++)
            value[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         dp_in = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 15) == 0) hex_en   = ~hex_en;
         if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
         if ($urandom_range(0, 9) == 0)  en       = ~en;
         step(1);
      end
      rst = 1'b0; load = 1'b0;
      step(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
